// File: rtl/cos_req_scheduler.sv
// Round-robin scheduler sharing one iterative cosine engine between two requesters.
// A watchdog turns a hung engine into an error response so requesters never deadlock.
module cos_req_scheduler #(
   parameter int unsigned START_CYCLES = 4,
   parameter int unsigned TIMEOUT      = 1023,
   parameter int unsigned CNT_W        = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [9:0] req0_x,
   input  logic [7:0] req0_y,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [9:0] req1_x,
   input  logic [7:0] req1_y,
   output logic       req1_ready,
   output logic       rsp0_valid,
   output logic       rsp1_valid,
   output logic [1:0] rsp_intpart,
   output logic [7:0] rsp_fracpart,
   output logic       rsp_err,
   output logic       busy,
   output logic       eng_start,
   output logic [9:0] eng_x,
   output logic [7:0] eng_y,
   input  logic [1:0] eng_intpart,
   input  logic [7:0] eng_fracpart,
   input  logic       eng_done
);

   localparam int unsigned SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [SC_W-1:0]  SC_LAST = SC_W'(START_CYCLES - 1);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_ACK,
      WAIT_DONE,
      RESP
   } state_t;

   state_t           state;
   logic             prio;      // 1: req1 wins a tie
   logic             gnt1;      // operation in flight belongs to req1
   logic [SC_W-1:0]  scnt;
   logic [CNT_W-1:0] wdog;
   logic             acc0;
   logic             acc1;
   logic             wd_exp;

   always_comb begin
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (!rst && state == IDLE) begin
         acc0 = req0_valid && (!req1_valid || !prio);
         acc1 = req1_valid && (!req0_valid || prio);
      end
   end

   assign req0_ready = acc0;
   assign req1_ready = acc1;
   // Expires on the TIMEOUT-th cycle spent in WAIT_ACK/WAIT_DONE
   assign wd_exp     = (wdog == WD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         prio         <= 1'b0;
         gnt1         <= 1'b0;
         scnt         <= '0;
         wdog         <= '0;
         eng_start    <= 1'b0;
         eng_x        <= '0;
         eng_y        <= '0;
         rsp0_valid   <= 1'b0;
         rsp1_valid   <= 1'b0;
         rsp_intpart  <= '0;
         rsp_fracpart <= '0;
         rsp_err      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (acc0 || acc1) begin
                  eng_x     <= acc1 ? req1_x : req0_x;
                  eng_y     <= acc1 ? req1_y : req0_y;
                  gnt1      <= acc1;
                  prio      <= acc0;
                  scnt      <= '0;
                  eng_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               if (scnt == SC_LAST) begin
                  eng_start <= 1'b0;
                  wdog      <= '0;
                  state     <= WAIT_ACK;
               end else begin
                  scnt <= scnt + 1'b1;
               end
            end
            WAIT_ACK: begin
               wdog <= wdog + 1'b1;
               if (wd_exp) begin
                  rsp_intpart  <= '0;
                  rsp_fracpart <= '0;
                  rsp_err      <= 1'b1;
                  rsp0_valid   <= !gnt1;
                  rsp1_valid   <= gnt1;
                  state        <= RESP;
               end else if (!eng_done) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               wdog <= wdog + 1'b1;
               if (eng_done) begin
                  rsp_intpart  <= eng_intpart;
                  rsp_fracpart <= eng_fracpart;
                  rsp_err      <= 1'b0;
                  rsp0_valid   <= !gnt1;
                  rsp1_valid   <= gnt1;
                  state        <= RESP;
               end else if (wd_exp) begin
                  rsp_intpart  <= '0;
                  rsp_fracpart <= '0;
                  rsp_err      <= 1'b1;
                  rsp0_valid   <= !gnt1;
                  rsp1_valid   <= gnt1;
                  state        <= RESP;
               end
            end
            RESP: begin
               rsp0_valid <= 1'b0;
               rsp1_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cos_req_scheduler.sv
// Scoreboard bench for cos_req_scheduler: randomized requesters, behavioural engine
// model, and a monitor that checks grants, engine handshake and responses.
module tb_cos_req_scheduler;

   localparam int unsigned START_CYCLES = 4;
   localparam int unsigned TIMEOUT      = 1023;
   localparam int unsigned CNT_W        = 10;

   typedef struct {
      logic [9:0] x;
      logic [7:0] y;
   } op_t;

   typedef struct {
      bit         who;
      logic [1:0] ip;
      logic [7:0] fp;
      bit         err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid, req1_valid;
   logic [9:0] req0_x, req1_x;
   logic [7:0] req0_y, req1_y;
   logic       req0_ready, req1_ready;
   logic       rsp0_valid, rsp1_valid, rsp_err, busy, eng_start;
   logic [1:0] rsp_intpart;
   logic [7:0] rsp_fracpart;
   logic [9:0] eng_x;
   logic [7:0] eng_y;
   logic [1:0] eng_intpart  = 2'b00;
   logic [7:0] eng_fracpart = 8'h00;
   logic       eng_done     = 1'b1;

   cos_req_scheduler #(
      .START_CYCLES(START_CYCLES),
      .TIMEOUT     (TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_x      (req0_x),
      .req0_y      (req0_y),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_x      (req1_x),
      .req1_y      (req1_y),
      .req1_ready  (req1_ready),
      .rsp0_valid  (rsp0_valid),
      .rsp1_valid  (rsp1_valid),
      .rsp_intpart (rsp_intpart),
      .rsp_fracpart(rsp_fracpart),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .eng_start   (eng_start),
      .eng_x       (eng_x),
      .eng_y       (eng_y),
      .eng_intpart (eng_intpart),
      .eng_fracpart(eng_fracpart),
      .eng_done    (eng_done)
   );

   always #5 clk = ~clk;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Engine model: done drops 2 cycles after start falls, rises 20 cycles later
   bit         hang = 0;
   logic       est_q = 1'b0;
   int         ecnt = -1;
   logic [9:0] ex;
   logic [7:0] ey;

   always @(posedge clk) begin
      if (rst) begin
         eng_done     <= 1'b1;
         eng_intpart  <= 2'b00;
         eng_fracpart <= 8'h00;
         est_q        <= 1'b0;
         ecnt         <= -1;
      end else begin
         est_q <= eng_start;
         if (est_q && !eng_start) begin
            ecnt <= 1;
            ex   <= eng_x;
            ey   <= eng_y;
         end else if (ecnt >= 0) begin
            ecnt <= ecnt + 1;
            if (ecnt == 2) eng_done <= 1'b0;
            if (ecnt == 22) begin
               ecnt <= -1;
               if (!hang) begin
                  eng_done     <= 1'b1;
                  eng_intpart  <= ex[9:8];
                  eng_fracpart <= ex[7:0] ^ ey;
               end
            end
         end
      end
   end

   // Requester drivers: each keeps valid high while its queue holds work
   op_t q0[$];
   op_t q1[$];
   bit  acc0 = 0;
   bit  acc1 = 0;

   initial begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_x = '0;
      req0_y = '0;
      req1_x = '0;
      req1_y = '0;
      forever begin
         @(posedge clk);
         #1;
         if (acc0) begin
            if (q0.size() != 0) void'(q0.pop_front());
            acc0 = 0;
         end
         if (acc1) begin
            if (q1.size() != 0) void'(q1.pop_front());
            acc1 = 0;
         end
         req0_valid = (q0.size() != 0);
         if (req0_valid) begin
            req0_x = q0[0].x;
            req0_y = q0[0].y;
         end
         req1_valid = (q1.size() != 0);
         if (req1_valid) begin
            req1_x = q1[0].x;
            req1_y = q1[0].y;
         end
      end
   end

   // Monitor / scoreboard
   exp_t       sbq[$];
   exp_t       e;
   int         cyc = 0;
   int         t_ack = 0;
   int         start_len = 0;
   int         outstanding = 0;
   int         nacc = 0;
   bit         last1 = 1;
   logic       e0, e1;
   logic [9:0] cur_x = '0;
   logic [7:0] cur_y = '0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         sbq.delete();
         outstanding = 0;
         last1       = 1;
         acc0        = 0;
         acc1        = 0;
         start_len   = 0;
      end else begin
         chk("busy", 64'(busy), 64'(outstanding != 0));
         if (busy) begin
            chk("eng_x", 64'(eng_x), 64'(cur_x));
            chk("eng_y", 64'(eng_y), 64'(cur_y));
         end
         if (eng_start) begin
            if (!busy) chk("start_idle", 64'(eng_start), 64'(0));
            start_len++;
         end else if (start_len != 0) begin
            chk("start_len", 64'(start_len), 64'(START_CYCLES));
            t_ack     = cyc;
            start_len = 0;
         end

         e0 = 1'b0;
         e1 = 1'b0;
         if (outstanding == 0) begin
            if (req0_valid && (!req1_valid || last1)) e0 = 1'b1;
            else if (req1_valid) e1 = 1'b1;
         end
         if (req0_valid || req1_valid || req0_ready || req1_ready)
            chk("ready", 64'({req0_ready, req1_ready}), 64'({e0, e1}));

         if (rsp0_valid || rsp1_valid) begin
            if (sbq.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL rsp_spurious: rsp0=%0b rsp1=%0b, expected no response (t=%0t)",
                        rsp0_valid, rsp1_valid, $time);
            end else begin
               e = sbq.pop_front();
               outstanding = 0;
               chk("rsp_who", 64'({rsp1_valid, rsp0_valid}), e.who ? 64'd2 : 64'd1);
               chk("rsp_intpart", 64'(rsp_intpart), 64'(e.ip));
               chk("rsp_fracpart", 64'(rsp_fracpart), 64'(e.fp));
               chk("rsp_err", 64'(rsp_err), 64'(e.err));
               if (e.err) chk("timeout_lat", 64'(cyc - t_ack), 64'(TIMEOUT));
            end
         end

         if (req0_valid && req0_ready) begin
            nacc++;
            outstanding = 1;
            last1 = 0;
            acc0  = 1;
            cur_x = req0_x;
            cur_y = req0_y;
            e.who = 0;
            e.err = hang;
            e.ip  = hang ? 2'b00 : req0_x[9:8];
            e.fp  = hang ? 8'h00 : (req0_x[7:0] ^ req0_y);
            sbq.push_back(e);
         end else if (req1_valid && req1_ready) begin
            nacc++;
            outstanding = 1;
            last1 = 1;
            acc1  = 1;
            cur_x = req1_x;
            cur_y = req1_y;
            e.who = 1;
            e.err = hang;
            e.ip  = hang ? 2'b00 : req1_x[9:8];
            e.fp  = hang ? 8'h00 : (req1_x[7:0] ^ req1_y);
            sbq.push_back(e);
         end
      end
   end

   // Stimulus helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [9:0] x, input logic [7:0] y);
      op_t o;
      o.x = x;
      o.y = y;
      q0.push_back(o);
   endtask

   task automatic push1(input logic [9:0] x, input logic [7:0] y);
      op_t o;
      o.x = x;
      o.y = y;
      q1.push_back(o);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({busy, eng_start, rsp0_valid, rsp1_valid, rsp_err, req0_ready, req1_ready}), 64'(0));
      chk({tag, "_rspbus"}, 64'({rsp_intpart, rsp_fracpart}), 64'(0));
      chk({tag, "_engops"}, 64'({eng_x, eng_y}), 64'(0));
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      rst = 1'b1;
      q0.delete();
      q1.delete();
      repeat (n) tick();
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_zero("reset");
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || outstanding != 0 || req0_valid || req1_valid)
             && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         nvec++;
         nerr++;
         $display("FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
      end
   endtask

   int unsigned m;
   int          nb;
   int          w;

   initial begin
      do_reset(3);

      // Single request on req0
      push0(10'h180, 8'h80);
      wait_idle(200);

      // Simultaneous pair straight after reset: req0 first, then req1
      do_reset(2);
      push0(10'h100, 8'h20);
      push1(10'h180, 8'h80);
      wait_idle(400);
      // Both requesters keep two operations queued: grants must alternate
      push0(10'h3a5, 8'h5c);
      push0(10'h0ff, 8'hff);
      push1(10'h2c3, 8'h11);
      push1(10'h001, 8'h01);
      wait_idle(800);

      // Back-to-back on req1 alone
      nb = nacc;
      push1(10'h155, 8'haa);
      push1(10'h2aa, 8'h55);
      push1(10'h3ff, 8'h00);
      wait_idle(600);
      chk("b2b_accepts", 64'(nacc - nb), 64'(3));

      // Hung engine: error response after TIMEOUT cycles, then a normal operation
      hang = 1;
      push0(10'h2f0, 8'h3c);
      wait_idle(TIMEOUT + 200);
      hang = 0;
      push0(10'h1e7, 8'h99);
      wait_idle(300);

      // Randomized mix of single, simultaneous and overlapping requests
      for (int i = 0; i < 30; i++) begin
         m = $urandom_range(0, 3);
         if (m != 1) push0(10'($urandom), 8'($urandom));
         if (m == 1 || m == 2) push1(10'($urandom), 8'($urandom));
         if (m == 3) begin
            repeat ($urandom_range(1, 12)) tick();
            push1(10'($urandom), 8'($urandom));
         end
         wait_idle(600);
         repeat ($urandom_range(0, 3)) tick();
      end

      // Reset while the engine is computing
      push0(10'h0c3, 8'h7e);
      w = 0;
      while (eng_done && w < 100) begin
         tick();
         w++;
      end
      chk("engine_began", 64'(eng_done), 64'(0));
      repeat (4) tick();
      rst = 1'b1;
      q0.delete();
      q1.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_zero("midop");
      repeat (30) tick();
      push0(10'h211, 8'h0f);
      push1(10'h0aa, 8'hf0);
      wait_idle(400);
      push1(10'h3c3, 8'h3c);
      wait_idle(200);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
